// File: rtl/npu_csr_pkg.sv
// Shared types and register map for the NPU CSR block.
// Build option: NPU_CSR_PERF_EN adds the PERF busy-cycle counter.
package npu_csr_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_BASE    = 3'd2;
    localparam logic [2:0] OFF_LEN     = 3'd3;
    localparam logic [2:0] OFF_SCRATCH = 3'd4;
    localparam logic [2:0] OFF_VERSION = 3'd5;
    localparam logic [2:0] OFF_PERF    = 3'd6;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[i*8 +: 8] = data[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bus bundle: 32-bit address/data, byte strobes.
// Modport m is the requester side, s the responder side.
interface axil_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport m (
        output awvalid, awaddr, wvalid, wdata, wstrb,
        output bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp
    );

    modport s (
        input  awvalid, awaddr, wvalid, wdata, wstrb,
        input  bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/npu_csr_axil_front.sv
// AXI4-Lite front end: AW/W hold slots and B/R response registers.
// Presents single-cycle write/read strobes to the register file.
module npu_csr_axil_front
    import npu_csr_pkg::*;
(
    input  logic        clk,
    input  logic        arst,
    axil_if.s           bus,
    output logic        wr_en,
    output logic [2:0]  wr_off,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_strb,
    input  resp_t       wr_resp,
    output logic        rd_en,
    output logic [2:0]  rd_off,
    input  logic [31:0] rd_data,
    input  resp_t       rd_resp
);

    logic        rdy_en;
    logic        aw_held;
    logic        w_held;
    logic [2:0]  aw_off_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_fire;
    logic        w_fire;

    // Only addr[4:2] selects a register.
    wire unused_addr = ^{bus.awaddr[31:5], bus.awaddr[1:0],
                         bus.araddr[31:5], bus.araddr[1:0]};

    assign bus.awready = rdy_en & ~aw_held & ~bus.bvalid;
    assign bus.wready  = rdy_en & ~w_held & ~bus.bvalid;
    assign bus.arready = rdy_en & ~bus.rvalid;

    assign aw_fire = bus.awvalid & bus.awready;
    assign w_fire  = bus.wvalid & bus.wready;

    assign wr_en   = (aw_held | aw_fire) & (w_held | w_fire);
    assign wr_off  = aw_held ? aw_off_q : bus.awaddr[4:2];
    assign wr_data = w_held ? w_data_q : bus.wdata;
    assign wr_strb = w_held ? w_strb_q : bus.wstrb;

    assign rd_en  = bus.arvalid & bus.arready;
    assign rd_off = bus.araddr[4:2];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rdy_en    <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_off_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bus.bvalid <= 1'b0;
            bus.bresp  <= RESP_OKAY;
        end else begin
            rdy_en <= 1'b1;
            if (wr_en) begin
                aw_held    <= 1'b0;
                w_held     <= 1'b0;
                bus.bvalid <= 1'b1;
                bus.bresp  <= wr_resp;
            end else begin
                if (aw_fire) begin
                    aw_held  <= 1'b1;
                    aw_off_q <= bus.awaddr[4:2];
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= bus.wdata;
                    w_strb_q <= bus.wstrb;
                end
                if (bus.bvalid && bus.bready)
                    bus.bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
            bus.rresp  <= RESP_OKAY;
        end else if (rd_en) begin
            bus.rvalid <= 1'b1;
            bus.rdata  <= rd_data;
            bus.rresp  <= rd_resp;
        end else if (bus.rvalid && bus.rready) begin
            bus.rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/npu_csr_regfile.sv
// NPU control/status register file behind an AXI4-Lite responder.
// Build option: NPU_CSR_PERF_EN maps the PERF busy-cycle counter at 0x18.
module npu_csr_regfile
    import npu_csr_pkg::*;
#(
    parameter int          LEN_W   = 24,
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic             clk,
    input  logic             arst,
    axil_if.s                csr,
    output logic             npu_start,
    output logic [31:0]      cfg_base,
    output logic [LEN_W-1:0] cfg_len,
    input  logic             npu_busy,
    input  logic             npu_done,
    output logic             irq
);

    logic        wr_en;
    logic [2:0]  wr_off;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    resp_t       wr_resp;
    logic        rd_en;
    logic [2:0]  rd_off;
    logic [31:0] rd_data;
    resp_t       rd_resp;

    logic        irq_en;
    logic        done;
    logic [31:0] scratch;
    logic [31:0] len_ext;
    logic        start_req;
    logic        done_clr;

    npu_csr_axil_front u_front (
        .clk     (clk),
        .arst    (arst),
        .bus     (csr),
        .wr_en   (wr_en),
        .wr_off  (wr_off),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .wr_resp (wr_resp),
        .rd_en   (rd_en),
        .rd_off  (rd_off),
        .rd_data (rd_data),
        .rd_resp (rd_resp)
    );

    always_comb begin
        len_ext = '0;
        len_ext[LEN_W-1:0] = cfg_len;
    end

    assign start_req = wr_en & (wr_off == OFF_CTRL) & wr_strb[0]
                     & wr_data[CTRL_START];
    assign done_clr  = wr_en & (wr_off == OFF_STATUS) & wr_strb[0]
                     & wr_data[STAT_DONE];

    always_comb begin
        wr_resp = RESP_OKAY;
        case (wr_off)
            OFF_CTRL, OFF_STATUS, OFF_BASE,
            OFF_LEN, OFF_SCRATCH, OFF_VERSION: wr_resp = RESP_OKAY;
`ifdef NPU_CSR_PERF_EN
            OFF_PERF: wr_resp = RESP_OKAY;
`endif
            default: wr_resp = RESP_SLVERR;
        endcase
        // A start request while the core is busy is refused.
        if (start_req && npu_busy)
            wr_resp = RESP_SLVERR;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            npu_start <= 1'b0;
            irq       <= 1'b0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            cfg_base  <= '0;
            cfg_len   <= '0;
            scratch   <= '0;
        end else begin
            npu_start <= start_req & ~npu_busy;
            irq       <= done & irq_en;
            if (npu_done)
                done <= 1'b1;
            else if (done_clr)
                done <= 1'b0;
            if (wr_en && wr_off == OFF_CTRL && wr_strb[0])
                irq_en <= wr_data[CTRL_IRQ_EN];
            if (wr_en && wr_off == OFF_BASE)
                cfg_base <= strb_merge(cfg_base, wr_data, wr_strb);
            if (wr_en && wr_off == OFF_LEN)
                cfg_len <= LEN_W'(strb_merge(len_ext, wr_data, wr_strb));
            if (wr_en && wr_off == OFF_SCRATCH)
                scratch <= strb_merge(scratch, wr_data, wr_strb);
        end
    end

`ifdef NPU_CSR_PERF_EN
    logic [31:0] perf;

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            perf <= '0;
        else if (npu_start)
            perf <= '0;
        else if (npu_busy)
            perf <= perf + 32'd1;
    end
`endif

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        if (rd_en) begin
            case (rd_off)
                OFF_CTRL:    rd_data[CTRL_IRQ_EN] = irq_en;
                OFF_STATUS:  rd_data[1:0] = {done, npu_busy};
                OFF_BASE:    rd_data = cfg_base;
                OFF_LEN:     rd_data = len_ext;
                OFF_SCRATCH: rd_data = scratch;
                OFF_VERSION: rd_data = VERSION;
`ifdef NPU_CSR_PERF_EN
                OFF_PERF:    rd_data = perf;
`endif
                default:     rd_resp = RESP_SLVERR;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_csr_regfile.sv
// Directed bench for npu_csr_regfile with a B/R response scoreboard.
// Define NPU_CSR_PERF_EN to exercise the PERF counter.
module tb_npu_csr_regfile;
    import npu_csr_pkg::*;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        npu_start;
    logic        npu_busy = 1'b0;
    logic        npu_done = 1'b0;
    logic        irq;
    logic [31:0] cfg_base;
    logic [23:0] cfg_len;

    always #5 clk = ~clk;

    axil_if bus ();

    npu_csr_regfile #(.LEN_W(24), .VERSION(32'h0001_0000)) dut (
        .clk       (clk),
        .arst      (arst),
        .csr       (bus),
        .npu_start (npu_start),
        .cfg_base  (cfg_base),
        .cfg_len   (cfg_len),
        .npu_busy  (npu_busy),
        .npu_done  (npu_done),
        .irq       (irq)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pop and compare whenever a B or R beat handshakes.
    always @(negedge clk) begin
        if (!arst) begin
            if (bus.bvalid && bus.bready) begin
                if (bq.size() == 0) fail("b_unexpected");
                else chk("bresp", 32'(bus.bresp), 32'(bq.pop_front()));
            end
            if (bus.rvalid && bus.rready) begin
                if (rq.size() == 0) begin
                    fail("r_unexpected");
                end else begin
                    logic [33:0] e;
                    e = rq.pop_front();
                    chk("rdata", bus.rdata, e[31:0]);
                    chk("rresp", 32'(bus.rresp), 32'(e[33:32]));
                end
            end
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain_b();
        int n = 0;
        while ((bq.size() != 0 || bus.bvalid) && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) fail("b_timeout");
    endtask

    task automatic drain_all();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) fail("drain_timeout");
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int aw_dly,
                      input int w_dly, input resp_t exp);
        bit aw_done = 0;
        bit w_done = 0;
        bit a_hs;
        bit w_hs;
        int t = 0;
        drain_b();
        bq.push_back(exp);
        bus.awaddr = addr;
        bus.wdata  = data;
        bus.wstrb  = strb;
        while (!(aw_done && w_done) && t < 50) begin
            bus.awvalid = !aw_done && t >= aw_dly;
            bus.wvalid  = !w_done && t >= w_dly;
            @(negedge clk);
            chk("bvalid_early", 32'(bus.bvalid), 0);
            a_hs = bus.awvalid && bus.awready;
            w_hs = bus.wvalid && bus.wready;
            @(posedge clk);
            #1;
            if (a_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            t++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (!(aw_done && w_done)) fail("wr_timeout");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_d,
                      input resp_t exp_r);
        bit hs = 0;
        int n = 0;
        rq.push_back({exp_r, exp_d});
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = bus.arvalid && bus.arready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.arvalid = 1'b0;
        if (!hs) fail("rd_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awvalid = 0; bus.awaddr = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.bready = 1; bus.arvalid = 0; bus.araddr = 0;
        bus.rready = 1;

        cyc(3);
        chk("rst_rdy_vld", 32'({bus.awready, bus.wready, bus.arready,
                                bus.bvalid, bus.rvalid}), 0);
        chk("rst_resp", 32'({bus.bresp, bus.rresp}), 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_outs", 32'({npu_start, irq}), 0);
        chk("rst_base", cfg_base, 0);
        chk("rst_len", 32'(cfg_len), 0);
        arst = 1'b0;
        cyc();

        rd(32'h04, 32'h0, RESP_OKAY);
        rd(32'h14, 32'h0001_0000, RESP_OKAY);

        // AW first, W three cycles later.
        wr(32'h08, 32'hDEAD_BEEF, 4'hF, 0, 3, RESP_OKAY);
        chk("bvalid_edge3", 32'(bus.bvalid), 1);
        chk("cfg_base", cfg_base, 32'hDEAD_BEEF);
        rd(32'h08, 32'hDEAD_BEEF, RESP_OKAY);

        // W before AW with a partial strobe; upper addr bits alias.
        wr(32'h10, 32'h1111_1111, 4'hF, 0, 0, RESP_OKAY);
        wr(32'h10, 32'h0000_AB00, 4'h2, 2, 0, RESP_OKAY);
        rd(32'h1000_0013, 32'h1111_AB11, RESP_OKAY);

        wr(32'h0C, 32'hFFFF_FFFF, 4'hF, 1, 1, RESP_OKAY);
        chk("cfg_len", 32'(cfg_len), 32'h00FF_FFFF);
        rd(32'h0C, 32'h00FF_FFFF, RESP_OKAY);

        // START while idle: one-cycle pulse; IRQ_EN reads back.
        wr(32'h00, 32'h3, 4'hF, 0, 0, RESP_OKAY);
        chk("start_pulse", 32'(npu_start), 1);
        cyc();
        chk("start_width", 32'(npu_start), 0);
        rd(32'h00, 32'h2, RESP_OKAY);

        // START while busy: refused.
        npu_busy = 1'b1;
        wr(32'h00, 32'h3, 4'hF, 0, 0, RESP_SLVERR);
        chk("busy_nostart0", 32'(npu_start), 0);
        cyc();
        chk("busy_nostart1", 32'(npu_start), 0);
        rd(32'h04, 32'h1, RESP_OKAY);
        npu_busy = 1'b0;
        drain_all();

        // Done pulse raises DONE, irq follows one cycle later.
        npu_done = 1'b1;
        cyc();
        npu_done = 1'b0;
        chk("irq_lat", 32'(irq), 0);
        cyc();
        chk("irq_set", 32'(irq), 1);
        rd(32'h04, 32'h2, RESP_OKAY);

        // W1C coincident with another done: set wins.
        npu_done = 1'b1;
        wr(32'h04, 32'h2, 4'h1, 0, 0, RESP_OKAY);
        npu_done = 1'b0;
        rd(32'h04, 32'h2, RESP_OKAY);
        wr(32'h04, 32'h2, 4'h1, 0, 0, RESP_OKAY);
        rd(32'h04, 32'h0, RESP_OKAY);
        cyc(2);
        chk("irq_clr", 32'(irq), 0);

        // RO and unmapped writes.
        wr(32'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, RESP_OKAY);
        rd(32'h14, 32'h0001_0000, RESP_OKAY);
        wr(32'h1C, 32'h1234_5678, 4'hF, 0, 1, RESP_SLVERR);
        rd(32'h10, 32'h1111_AB11, RESP_OKAY);
        drain_all();

        // Unmapped read with R held off for five cycles.
        bus.rready = 1'b0;
        rd(32'h1C, 32'h0, RESP_SLVERR);
        for (int i = 0; i < 5; i++) begin
            chk("r_hold_vld", 32'(bus.rvalid), 1);
            chk("r_hold_data", bus.rdata, 0);
            chk("r_hold_arrdy", 32'(bus.arready), 0);
            cyc();
        end
        bus.rready = 1'b1;
        drain_all();

`ifdef NPU_CSR_PERF_EN
        wr(32'h00, 32'h1, 4'h1, 0, 0, RESP_OKAY);
        chk("perf_start", 32'(npu_start), 1);
        cyc();
        npu_busy = 1'b1;
        cyc(100);
        npu_busy = 1'b0;
        rd(32'h18, 32'd100, RESP_OKAY);
        wr(32'h18, 32'h0, 4'hF, 0, 0, RESP_OKAY);
        rd(32'h18, 32'd100, RESP_OKAY);
`else
        wr(32'h18, 32'h5, 4'hF, 0, 0, RESP_SLVERR);
        rd(32'h18, 32'h0, RESP_SLVERR);
`endif
        drain_all();

        // Async reset while a B response is pending.
        bus.bready = 1'b0;
        wr(32'h08, 32'h1234_5678, 4'hF, 0, 0, RESP_OKAY);
        cyc(2);
        chk("b_pending", 32'(bus.bvalid), 1);
        bq.delete();
        arst = 1'b1;
        #1;
        chk("arst_bvalid", 32'(bus.bvalid), 0);
        chk("arst_base", cfg_base, 0);
        chk("arst_len", 32'(cfg_len), 0);
        cyc(2);
        arst = 1'b0;
        bus.bready = 1'b1;
        cyc();
        rd(32'h00, 32'h0, RESP_OKAY);
        rd(32'h04, 32'h0, RESP_OKAY);
        rd(32'h08, 32'h0, RESP_OKAY);
        rd(32'h0C, 32'h0, RESP_OKAY);
        rd(32'h10, 32'h0, RESP_OKAY);
        drain_all();
        chk("queues_empty", 32'(bq.size() + rq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
